core_list_scanner: RTL
======================

Name: core_list_scanner

Overview:
- AXI4-Lite read master that sits directly upstream of the core list ROM slave and drives its read channels.
- On a start pulse it walks the ROM word by word from a base address and re-emits each word as a one-cycle stream beat.
- It keeps a running 32-bit checksum and reports done or error status.
- Used for autonomous core discovery and power-up self-check, without CPU involvement.

Parameters:
- BaseAddr_Con, 16'h0000, byte address of the first ROM word.
- WordCount_Con, 256, maximum number of 32-bit words to read (1..65535).
- TimeoutCycles_Gen, 1023, cycles allowed waiting for ARREADY or RVALID before aborting (>=1).

Ports:
- SysClk_ClkIn  in  1  system clock.
- SysRst_RstIn  in  1  reset, asynchronous, active-high.
- ScanStart_EvtIn  in  1  single-cycle start pulse.
- ScanBusy_DatOut  out  1  scan in progress.
- ScanDone_DatOut  out  1  sticky, scan completed without error.
- ScanError_DatOut  out  1  sticky, scan aborted (bad RRESP or timeout).
- WordValid_ValOut  out  1  one-cycle beat qualifier.
- WordData_DatOut  out  32  word read.
- WordIndex_DatOut  out  16  index of the word read.
- WordsRead_DatOut  out  16  count of accepted words.
- Checksum_DatOut  out  32  mod-2^32 sum of accepted words.
- AxiReadAddrValid_ValOut  out  1  ARVALID.
- AxiReadAddrReady_RdyIn  in  1  ARREADY.
- AxiReadAddrAddress_AdrOut  out  16  ARADDR.
- AxiReadAddrProt_DatOut  out  3  ARPROT, constant 3'b000.
- AxiReadDataValid_ValIn  in  1  RVALID.
- AxiReadDataReady_RdyOut  out  1  RREADY.
- AxiReadDataResponse_DatIn  in  2  RRESP.
- AxiReadDataData_DatIn  in  32  RDATA.
- The write channels of the slave are tied inactive by the instantiating level; this block has no write ports.

Behaviour:
- Reset (async, active-high): every output is 0, FSM goes to IDLE, index/count/checksum/timeout counter clear. Reset mid-scan aborts immediately with no further AXI activity.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - ScanStart_EvtIn=1 clears Done, Error, WordsRead, Checksum and index, sets Busy, then goes to ADDR.
  - A start pulse outside IDLE is ignored.
- ADDR:
  - ARVALID=1 with ARADDR = BaseAddr_Con + 4*index, computed mod 2^16 so it wraps.
  - ARADDR is held stable until ARVALID&&ARREADY, then go to DATA.
- DATA:
  - RREADY=1.
  - On RVALID&&RREADY with RRESP=2'b00, on the next edge:
    - WordValid=1 for one cycle, with WordData=RDATA and WordIndex=index.
    - WordsRead+1; Checksum += RDATA, wrapping mod 2^32.
  - If index==WordCount_Con-1: Done=1, Busy=0, go to IDLE. Otherwise index+1, go to ADDR.
  - On RVALID with RRESP!=0: Error=1, Busy=0, go to IDLE. No beat, no count or checksum change.
- Timeout:
  - A counter runs while in ADDR or DATA and clears on each completed handshake.
  - When it reaches TimeoutCycles_Gen: Error=1, ARVALID=0, RREADY=0, Busy=0, go to IDLE.
  - This is a deliberate abort; the slave is expected to be reset before reuse.
- Throughput: at most one outstanding read. With a zero-wait slave each word costs 2 cycles, ADDR then DATA.
- Done and Error are mutually exclusive. Both hold until the next accepted start or reset.

Optional Feature:
- Macro: CORE_LIST_SCAN_ENDMARK_EN.
- Defined: an accepted word equal to 32'h0000_0000 is the end marker. It is emitted as a beat, counted, and summed; Done then asserts and the FSM returns to IDLE even if WordCount_Con is not reached.
- Undefined: zero words are ordinary data and the scan always reads exactly WordCount_Con words.

Test Plan:
- WordCount_Con=4, zero-wait slave returning 1,2,3,4 -> ARADDR sequence 0x0,0x4,0x8,0xC; four beats with indices 0..3; Checksum=10; WordsRead=4; Done=1; Error=0; Busy low 8 cycles after start.
- ARREADY delayed 5 cycles on word 1 -> ARVALID high and ARADDR=0x4 stable across all 5 cycles; the result otherwise matches the first case.
- RRESP=2'b10 on index 2 -> Error=1; Done=0; WordsRead=2; no beat with index 2; Checksum=3.
- TimeoutCycles_Gen=16, slave never asserts ARREADY -> Error=1 after 16 cycles in ADDR, ARVALID drops, Busy=0.
- Start pulse while Busy is ignored (scan finishes normally). Reset asserted mid-DATA -> all outputs 0 asynchronously, before the next clock edge.
- Macro defined, WordCount_Con=8, data 5,0,7 -> stops after index 1; WordsRead=2; Checksum=5; Done=1; no ARVALID for index 2.

Source files
------------

// File: rtl/core_list_scanner.sv
`default_nettype none
// ============================================================================
// Module   : core_list_scanner
// Purpose  : AXI4-Lite read master that walks the core list ROM from a base
//            address and re-emits every word as a one-cycle stream beat. It
//            keeps a running 32-bit checksum and sticky done/error flags.
//            At most one read is outstanding. A zero-wait slave therefore
//            costs two cycles per word: one in ADDR, then one in DATA.
// Ports    : SysClk_ClkIn / SysRst_RstIn        clock, async active-high reset
//            ScanStart_EvtIn                    start pulse (ignored unless idle)
//            ScanBusy/Done/Error_DatOut         scan status
//            WordValid/WordData/WordIndex       output word stream
//            WordsRead/Checksum_DatOut          accepted-word statistics
//            AxiReadAddr* / AxiReadData*        AR and R channels to the ROM
// Macro    : CORE_LIST_SCAN_ENDMARK_EN - when defined, an accepted zero word
//            ends the scan early. It is still emitted, counted and summed.
// Revision : 1.0 - initial release
// ============================================================================
module core_list_scanner #(
  parameter logic [15:0] BaseAddr_Con      = 16'h0000,
  parameter int          WordCount_Con     = 256,
  parameter int          TimeoutCycles_Gen = 1023
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRst_RstIn,
  input  logic        ScanStart_EvtIn,
  output logic        ScanBusy_DatOut,
  output logic        ScanDone_DatOut,
  output logic        ScanError_DatOut,
  output logic        WordValid_ValOut,
  output logic [31:0] WordData_DatOut,
  output logic [15:0] WordIndex_DatOut,
  output logic [15:0] WordsRead_DatOut,
  output logic [31:0] Checksum_DatOut,
  output logic        AxiReadAddrValid_ValOut,
  input  logic        AxiReadAddrReady_RdyIn,
  output logic [15:0] AxiReadAddrAddress_AdrOut,
  output logic [2:0]  AxiReadAddrProt_DatOut,
  input  logic        AxiReadDataValid_ValIn,
  output logic        AxiReadDataReady_RdyOut,
  input  logic [1:0]  AxiReadDataResponse_DatIn,
  input  logic [31:0] AxiReadDataData_DatIn
);

  localparam logic [1:0] c_STATE_IDLE = 2'd0;
  localparam logic [1:0] c_STATE_ADDR = 2'd1;
  localparam logic [1:0] c_STATE_DATA = 2'd2;

  // The timer only has to count to TimeoutCycles_Gen-1.
  localparam int                 c_TMR_W     = (TimeoutCycles_Gen > 1) ? $clog2(TimeoutCycles_Gen) : 1;
  localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(TimeoutCycles_Gen - 1);
  localparam logic [15:0]        c_LAST_WORD = 16'(WordCount_Con - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_nextState;
  logic [15:0]        r_index;
  logic [c_TMR_W-1:0] r_timer;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_wordValid;
  logic [31:0]        r_wordData;
  logic [15:0]        r_wordIndex;
  logic [15:0]        r_wordsRead;
  logic [31:0]        r_checksum;

  logic        w_arValid;
  logic        w_rReady;
  logic [15:0] w_arAddr;
  logic        w_addrHs;
  logic        w_dataHs;
  logic        w_dataOk;
  logic        w_dataBad;
  logic        w_timeout;
  logic        w_lastWord;

  assign w_addrHs  = w_arValid && AxiReadAddrReady_RdyIn;
  assign w_dataHs  = w_rReady && AxiReadDataValid_ValIn;
  assign w_dataOk  = w_dataHs && (AxiReadDataResponse_DatIn == 2'b00);
  assign w_dataBad = w_dataHs && (AxiReadDataResponse_DatIn != 2'b00);

  // A handshake on the final waiting cycle still wins over the abort.
  assign w_timeout = (r_state != c_STATE_IDLE) && !(w_addrHs || w_dataHs) &&
                     (r_timer == c_TMR_LAST);

`ifdef CORE_LIST_SCAN_ENDMARK_EN
  assign w_lastWord = (r_index == c_LAST_WORD) || (AxiReadDataData_DatIn == 32'h0000_0000);
`else
  assign w_lastWord = (r_index == c_LAST_WORD);
`endif

  // State register.
  always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
    if (SysRst_RstIn) begin
      r_state <= c_STATE_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_STATE_IDLE: begin
        if (ScanStart_EvtIn) w_nextState = c_STATE_ADDR;
      end
      c_STATE_ADDR: begin
        if (w_timeout)     w_nextState = c_STATE_IDLE;
        else if (w_addrHs) w_nextState = c_STATE_DATA;
      end
      c_STATE_DATA: begin
        if (w_timeout || w_dataBad) w_nextState = c_STATE_IDLE;
        else if (w_dataOk)          w_nextState = w_lastWord ? c_STATE_IDLE : c_STATE_ADDR;
      end
      default: w_nextState = c_STATE_IDLE;
    endcase
  end

  // Bus outputs. The address is forced to zero outside ADDR so that every
  // output reads zero while reset is applied.
  always_comb begin
    w_arValid = (r_state == c_STATE_ADDR);
    w_rReady  = (r_state == c_STATE_DATA);
    w_arAddr  = 16'h0000;
    if (w_arValid) w_arAddr = BaseAddr_Con + {r_index[13:0], 2'b00};
  end

  // Index, statistics, status flags and timeout counter.
  always_ff @(posedge SysClk_ClkIn or posedge SysRst_RstIn) begin
    if (SysRst_RstIn) begin
      r_index     <= 16'h0000;
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_wordValid <= 1'b0;
      r_wordData  <= 32'h0000_0000;
      r_wordIndex <= 16'h0000;
      r_wordsRead <= 16'h0000;
      r_checksum  <= 32'h0000_0000;
    end else begin
      r_wordValid <= 1'b0;
      if (r_state == c_STATE_IDLE) begin
        r_timer <= '0;
        if (ScanStart_EvtIn) begin
          r_index     <= 16'h0000;
          r_busy      <= 1'b1;
          r_done      <= 1'b0;
          r_error     <= 1'b0;
          r_wordsRead <= 16'h0000;
          r_checksum  <= 32'h0000_0000;
        end
      end else begin
        if (w_addrHs || w_dataHs) r_timer <= '0;
        else                      r_timer <= r_timer + 1'b1;

        if (w_timeout) begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
        end else if (w_dataBad) begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
        end else if (w_dataOk) begin
          r_wordValid <= 1'b1;
          r_wordData  <= AxiReadDataData_DatIn;
          r_wordIndex <= r_index;
          r_wordsRead <= r_wordsRead + 16'd1;
          r_checksum  <= r_checksum + AxiReadDataData_DatIn;
          if (w_lastWord) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_index <= r_index + 16'd1;
          end
        end
      end
    end
  end

  assign ScanBusy_DatOut           = r_busy;
  assign ScanDone_DatOut           = r_done;
  assign ScanError_DatOut          = r_error;
  assign WordValid_ValOut          = r_wordValid;
  assign WordData_DatOut           = r_wordData;
  assign WordIndex_DatOut          = r_wordIndex;
  assign WordsRead_DatOut          = r_wordsRead;
  assign Checksum_DatOut           = r_checksum;
  assign AxiReadAddrValid_ValOut   = w_arValid;
  assign AxiReadAddrAddress_AdrOut = w_arAddr;
  assign AxiReadAddrProt_DatOut    = 3'b000;
  assign AxiReadDataReady_RdyOut   = w_rReady;

endmodule
`default_nettype wire
